// File: rtl/uart_cmd_master.sv
// uart_cmd_master: host-side initiator for the UART command protocol.
// Serialises one request as a 10-byte frame, then hunts for, collects and
// checks the 8-byte response, reporting status, data and an error class.
module uart_cmd_master #(
    parameter logic [23:0] TIMEOUT_CYC = 24'd1250000,
    parameter logic [7:0]  HDR0        = 8'hAA,
    parameter logic [7:0]  HDR1        = 8'h55
) (
    input  logic        clk_sys,
    input  logic        rst_sys,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic [7:0]  req_cmd,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_data,
    output logic        uart_tx_wen,
    output logic [7:0]  uart_tx_wdata,
    input  logic        uart_tx_rdy,
    input  logic        uart_rx_ren,
    input  logic [7:0]  uart_rx_rdata,
    output logic        rsp_vld,
    output logic [7:0]  rsp_status,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_BYTE,
        S_TX_GUARD,
        S_RX_WAIT,
        S_DONE
    } state_e;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // The guard cycle itself is the first timeout cycle, so the counter is
    // loaded one short: expiry lands exactly TIMEOUT_CYC cycles after it.
    localparam logic [23:0] TMO_LOAD = (TIMEOUT_CYC == 24'd0) ? 24'd0 : TIMEOUT_CYC - 24'd1;

    state_e      state_q, state_d;
    logic [3:0]  tx_idx_q, tx_idx_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic [23:0] tmo_q, tmo_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  rx_status_q, rx_status_d;
    logic [31:0] rx_data_q, rx_data_d;
    logic [7:0]  rsp_status_q, rsp_status_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [1:0]  rsp_err_q, rsp_err_d;

    logic        tx_wen;
    logic [7:0]  tx_byte;
    logic [7:0]  tx_csum;

    // Request checksum over cmd, address and data bytes (mod 256 by width).
    assign tx_csum = cmd_q + addr_q[15:8] + addr_q[7:0] + data_q[31:24]
                   + data_q[23:16] + data_q[15:8] + data_q[7:0];

    // Select the request frame byte addressed by the transmit index.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        tx_byte = 8'h00;
        case (tx_idx_q)
            4'd0:    tx_byte = HDR0;
            4'd1:    tx_byte = HDR1;
            4'd2:    tx_byte = cmd_q;
            4'd3:    tx_byte = addr_q[15:8];
            4'd4:    tx_byte = addr_q[7:0];
            4'd5:    tx_byte = data_q[31:24];
            4'd6:    tx_byte = data_q[23:16];
            4'd7:    tx_byte = data_q[15:8];
            4'd8:    tx_byte = data_q[7:0];
            4'd9:    tx_byte = tx_csum;
            default: tx_byte = 8'h00;
        endcase
    end

    // Next-state logic: transmit sequencing, header hunt, timeout, result.
    always_comb begin
        state_d      = state_q;
        tx_idx_d     = tx_idx_q;
        rx_idx_d     = rx_idx_q;
        tmo_d        = tmo_q;
        csum_d       = csum_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        data_d       = data_q;
        rx_status_d  = rx_status_q;
        rx_data_d    = rx_data_q;
        rsp_status_d = rsp_status_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        tx_wen       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_vld) begin
                    cmd_d    = req_cmd;
                    addr_d   = req_addr;
                    data_d   = req_data;
                    tx_idx_d = 4'd0;
                    state_d  = S_TX_BYTE;
                end
            end

            S_TX_BYTE: begin
                if (uart_tx_rdy) begin
                    tx_wen  = 1'b1;
                    state_d = S_TX_GUARD;
                end
            end

            // One dead cycle after every byte keeps write strobes apart.
            S_TX_GUARD: begin
                if (tx_idx_q != 4'd9) begin
                    tx_idx_d = tx_idx_q + 4'd1;
                    state_d  = S_TX_BYTE;
                end else begin
                    rx_idx_d = 3'd0;
                    csum_d   = 8'h00;
                    tmo_d    = TMO_LOAD;
                    state_d  = S_RX_WAIT;
                end
            end

            S_RX_WAIT: begin
                tmo_d = tmo_q - 24'd1;
                // The final byte takes priority over a coinciding expiry.
                if (uart_rx_ren && (rx_idx_q == 3'd7)) begin
                    rsp_status_d = rx_status_q;
                    rsp_data_d   = rx_data_q;
                    rsp_err_d    = (uart_rx_rdata == csum_q) ? ERR_OK : ERR_CSUM;
                    state_d      = S_DONE;
                end else if (tmo_q <= 24'd1) begin
                    rsp_status_d = 8'h00;
                    rsp_data_d   = 32'h0;
                    rsp_err_d    = ERR_TIMEOUT;
                    state_d      = S_DONE;
                end else if (uart_rx_ren) begin
                    case (rx_idx_q)
                        3'd0: begin
                            if (uart_rx_rdata == HDR0) rx_idx_d = 3'd1;
                        end
                        3'd1: begin
                            // A repeated HDR0 may itself start the real header.
                            if (uart_rx_rdata == HDR1)      rx_idx_d = 3'd2;
                            else if (uart_rx_rdata != HDR0) rx_idx_d = 3'd0;
                        end
                        3'd2: begin
                            rx_status_d = uart_rx_rdata;
                            csum_d      = csum_q + uart_rx_rdata;
                            rx_idx_d    = 3'd3;
                        end
                        default: begin
                            rx_data_d = {rx_data_q[23:0], uart_rx_rdata};
                            csum_d    = csum_q + uart_rx_rdata;
                            rx_idx_d  = rx_idx_q + 3'd1;
                        end
                    endcase
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst_sys) begin
            state_q      <= S_IDLE;
            tx_idx_q     <= 4'd0;
            rx_idx_q     <= 3'd0;
            tmo_q        <= 24'd0;
            csum_q       <= 8'h00;
            cmd_q        <= 8'h00;
            addr_q       <= 16'h0;
            data_q       <= 32'h0;
            rx_status_q  <= 8'h00;
            rx_data_q    <= 32'h0;
            rsp_status_q <= 8'h00;
            rsp_data_q   <= 32'h0;
            rsp_err_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            tx_idx_q     <= tx_idx_d;
            rx_idx_q     <= rx_idx_d;
            tmo_q        <= tmo_d;
            csum_q       <= csum_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            rx_status_q  <= rx_status_d;
            rx_data_q    <= rx_data_d;
            rsp_status_q <= rsp_status_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // req_rdy is masked by reset so every output reads 0 while it is held.
    assign req_rdy       = (state_q == S_IDLE) && !rst_sys;
    assign busy          = (state_q != S_IDLE);
    assign rsp_vld       = (state_q == S_DONE);
    assign uart_tx_wen   = tx_wen;
    assign uart_tx_wdata = tx_wen ? tx_byte : 8'h00;
    assign rsp_status    = rsp_status_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master: scoreboard bench for uart_cmd_master. Stimulus pushes
// expected TX bytes and responses into queues; monitors pop and compare.
`timescale 1ns/1ps
module tb_uart_cmd_master;

    localparam logic [7:0] H0 = 8'hAA;
    localparam logic [7:0] H1 = 8'h55;
    localparam int TMO = 100;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [7:0]  status;
        logic [31:0] data;
        logic [1:0]  err;
        int          at_cyc;
    } rsp_t;

    logic        clk_sys = 1'b0;
    logic        rst_sys;
    logic        req_vld;
    logic        req_rdy;
    logic [7:0]  req_cmd;
    logic [15:0] req_addr;
    logic [31:0] req_data;
    logic        uart_tx_wen;
    logic [7:0]  uart_tx_wdata;
    logic        uart_tx_rdy;
    logic        uart_rx_ren;
    logic [7:0]  uart_rx_rdata;
    logic        rsp_vld;
    logic [7:0]  rsp_status;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;
    logic        busy;

    uart_cmd_master #(.TIMEOUT_CYC(24'd100)) dut (
        .clk_sys       (clk_sys),
        .rst_sys       (rst_sys),
        .req_vld       (req_vld),
        .req_rdy       (req_rdy),
        .req_cmd       (req_cmd),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .uart_tx_wen   (uart_tx_wen),
        .uart_tx_wdata (uart_tx_wdata),
        .uart_tx_rdy   (uart_tx_rdy),
        .uart_rx_ren   (uart_rx_ren),
        .uart_rx_rdata (uart_rx_rdata),
        .rsp_vld       (rsp_vld),
        .rsp_status    (rsp_status),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .busy          (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc = cyc + 1;

    // Scoreboard state
    logic [7:0] tx_q[$];
    rsp_t       rsp_q[$];
    int         total = 0;
    int         bad = 0;
    int         last_wen_cyc = 0;
    int         tx_sent = 0;
    logic       prev_wen = 1'b0;
    logic       rdy_rand = 1'b0;
    logic [7:0] tx_exp;
    rsp_t       rsp_got;
    rsp_t       last_rsp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_test();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // ---------------- reference model ----------------
    task automatic push_req_frame(input logic [7:0] c, input logic [15:0] a, input logic [31:0] d);
        int s;
        s = int'(c) + int'(a[15:8]) + int'(a[7:0]) + int'(d[31:24])
          + int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0]);
        tx_q.push_back(H0);
        tx_q.push_back(H1);
        tx_q.push_back(c);
        tx_q.push_back(a[15:8]);
        tx_q.push_back(a[7:0]);
        tx_q.push_back(d[31:24]);
        tx_q.push_back(d[23:16]);
        tx_q.push_back(d[15:8]);
        tx_q.push_back(d[7:0]);
        tx_q.push_back(8'(s % 256));
    endtask

    // The response starts at the first adjacent HDR0,HDR1 pair in the stream.
    function automatic void decode(input byte_q_t s, output rsp_t r, output int last);
        int sum;
        r.status = 8'h00;
        r.data   = 32'h0;
        r.err    = 2'b00;
        r.at_cyc = 0;
        last     = -1;
        for (int i = 0; i + 7 < s.size(); i++) begin
            if (last < 0 && s[i] == H0 && s[i+1] == H1) begin
                r.status = s[i+2];
                r.data   = {s[i+3], s[i+4], s[i+5], s[i+6]};
                sum      = int'(s[i+2]) + int'(s[i+3]) + int'(s[i+4]) + int'(s[i+5]) + int'(s[i+6]);
                r.err    = ((sum % 256) == int'(s[i+7])) ? 2'b00 : 2'b01;
                last     = i + 7;
            end
        end
    endfunction

    function automatic void fill8(output byte_q_t q, input logic [63:0] v);
        q = {};
        for (int i = 7; i >= 0; i--) q.push_back(v[i*8 +: 8]);
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk_sys) begin
        if (uart_tx_wen === 1'b1) begin
            check("tx_wen_while_rdy_low", uart_tx_rdy, 1'b1);
            check("tx_back_to_back_wen", prev_wen, 1'b0);
            if (tx_q.size() == 0) begin
                check("tx_unexpected_wen", uart_tx_wen, 1'b0);
            end else begin
                tx_exp = tx_q.pop_front();
                check("tx_byte", uart_tx_wdata, tx_exp);
            end
            tx_sent++;
            last_wen_cyc = cyc;
        end
        prev_wen = (uart_tx_wen === 1'b1);
    end

    always @(negedge clk_sys) begin
        if (rsp_vld === 1'b1) begin
            if (rsp_q.size() == 0) begin
                check("rsp_unexpected_vld", rsp_vld, 1'b0);
            end else begin
                rsp_got = rsp_q.pop_front();
                check("rsp_status", rsp_status, rsp_got.status);
                check("rsp_data", rsp_data, rsp_got.data);
                check("rsp_err", rsp_err, rsp_got.err);
                check("rsp_cycle", cyc, rsp_got.at_cyc);
                last_rsp = rsp_got;
            end
        end
    end

    // Random TX back-pressure, applied only while enabled.
    initial begin
        forever begin
            @(posedge clk_sys);
            #2;
            if (rdy_rand) uart_tx_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_req_rdy();
        int n = 0;
        while (req_rdy !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("req_rdy_wait", req_rdy, 1'b1);
        if (req_rdy !== 1'b1) finish_test();
    endtask

    task automatic issue_req(input logic [7:0] c, input logic [15:0] a, input logic [31:0] d);
        wait_req_rdy();
        check("hold_status", rsp_status, last_rsp.status);
        check("hold_data", rsp_data, last_rsp.data);
        check("hold_err", rsp_err, last_rsp.err);
        tx_sent = 0;
        push_req_frame(c, a, d);
        req_vld  = 1'b1;
        req_cmd  = c;
        req_addr = a;
        req_data = d;
        tick();
        req_vld  = 1'b0;
        req_cmd  = 8'($urandom);
        req_addr = 16'($urandom);
        req_data = $urandom;
        check("busy_after_accept", busy, 1'b1);
        check("rdy_after_accept", req_rdy, 1'b0);
    endtask

    task automatic wait_tx_done(output int w);
        int n = 0;
        while (tx_q.size() != 0 && n < 600) begin
            tick();
            n++;
        end
        check("tx_frame_complete", tx_q.size(), 0);
        if (tx_q.size() != 0) finish_test();
        w = last_wen_cyc;
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_rx_ren   = 1'b1;
        uart_rx_rdata = b;
        tick();
        uart_rx_ren   = 1'b0;
    endtask

    // Send the stream from w+2+start (first RX_WAIT cycle is w+2).
    task automatic send_rsp(input byte_q_t s, input int w, input int start, input int gap_max);
        rsp_t r;
        int   last;
        decode(s, r, last);
        while (cyc < w + 2 + start) tick();
        for (int i = 0; i <= last; i++) begin
            if (i == last) begin
                r.at_cyc = cyc + 1;
                rsp_q.push_back(r);
            end
            send_byte(s[i]);
            if (i < last) repeat ($urandom_range(0, gap_max)) tick();
        end
    endtask

    task automatic push_timeout(input int w);
        rsp_t r;
        r.status = 8'h00;
        r.data   = 32'h0;
        r.err    = 2'b10;
        r.at_cyc = w + 1 + TMO;
        rsp_q.push_back(r);
    endtask

    task automatic wait_rsp_done();
        int n = 0;
        while (rsp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check("rsp_arrived", rsp_q.size(), 0);
        if (rsp_q.size() != 0) finish_test();
        tick();
    endtask

    task automatic check_all_zero(input string tag, input logic rdy_exp);
        check({tag, "_req_rdy"}, req_rdy, rdy_exp);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_wen"}, uart_tx_wen, 1'b0);
        check({tag, "_wdata"}, uart_tx_wdata, 8'h00);
        check({tag, "_rsp_vld"}, rsp_vld, 1'b0);
        check({tag, "_status"}, rsp_status, 8'h00);
        check({tag, "_data"}, rsp_data, 32'h0);
        check({tag, "_err"}, rsp_err, 2'b00);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        byte_q_t    s;
        int         w;
        logic [7:0] stray [4];
        logic [7:0] b, prev;
        int         n;

        last_rsp.status = 8'h00;
        last_rsp.data   = 32'h0;
        last_rsp.err    = 2'b00;
        last_rsp.at_cyc = 0;
        rst_sys = 1'b1; req_vld = 1'b0; req_cmd = 8'h00; req_addr = 16'h0; req_data = 32'h0;
        uart_tx_rdy = 1'b1; uart_rx_ren = 1'b0; uart_rx_rdata = 8'h00;

        // Reset state
        repeat (3) tick();
        check_all_zero("reset", 1'b0);
        rst_sys = 1'b0;
        #1;
        check("rdy_after_release", req_rdy, 1'b1);

        // Normal transaction
        issue_req(8'h01, 16'h0012, 32'h12345678);
        wait_tx_done(w);
        fill8(s, 64'hAA55_00DE_ADBE_EF38);
        send_rsp(s, w, 0, 0);
        wait_rsp_done();

        // Checksum error
        issue_req(8'h01, 16'h0012, 32'h12345678);
        wait_tx_done(w);
        fill8(s, 64'hAA55_00DE_ADBE_EF39);
        send_rsp(s, w, 1, 2);
        wait_rsp_done();

        // Header resync: 13 AA AA 55 ...
        issue_req(8'h01, 16'h0012, 32'h12345678);
        wait_tx_done(w);
        fill8(s, 64'hAA55_00DE_ADBE_EF38);
        s.push_front(8'hAA);
        s.push_front(8'h13);
        send_rsp(s, w, 0, 1);
        wait_rsp_done();

        // Timeout with no response
        issue_req(8'h10, 16'h4000, 32'h0000_0001);
        wait_tx_done(w);
        push_timeout(w);
        wait_rsp_done();

        // Back-pressure during byte 4, stray RX bytes and a request while busy
        stray[0] = H0; stray[1] = H1; stray[2] = 8'h00; stray[3] = 8'h11;
        issue_req(8'h02, 16'hBEEF, 32'hCAFEF00D);
        n = 0;
        while (tx_sent < 4 && n < 100) begin
            tick();
            n++;
        end
        uart_tx_rdy = 1'b0;
        for (int k = 0; k < 20; k++) begin
            req_vld = (k < 6);
            req_cmd = 8'($urandom);
            if (k >= 8 && k < 12) begin
                uart_rx_ren   = 1'b1;
                uart_rx_rdata = stray[k-8];
            end else begin
                uart_rx_ren = 1'b0;
            end
            tick();
            if (k < 6) check("rdy_while_busy", req_rdy, 1'b0);
        end
        req_vld     = 1'b0;
        uart_rx_ren = 1'b0;
        check("bp_no_wen_while_low", tx_sent, 4);
        uart_tx_rdy = 1'b1;
        wait_tx_done(w);
        fill8(s, 64'hAA55_5A01_0203_0460);
        send_rsp(s, w, 0, 0);
        wait_rsp_done();

        // Final byte coincides with the last RX_WAIT cycle: the byte wins
        issue_req(8'h03, 16'h0100, 32'h0);
        wait_tx_done(w);
        fill8(s, 64'hAA55_C301_0203_04CD);
        while (cyc < w + 2) tick();
        for (int i = 0; i < 7; i++) send_byte(s[i]);
        while (cyc < w + TMO) tick();
        s = s[0:6];
        s.push_back(8'hCD);
        begin
            rsp_t r;
            int   last;
            decode(s, r, last);
            r.at_cyc = cyc + 1;
            rsp_q.push_back(r);
        end
        send_byte(8'hCD);
        wait_rsp_done();

        // Reset abort during RX byte 3
        issue_req(8'h04, 16'h0203, 32'h0A0B0C0D);
        wait_tx_done(w);
        while (cyc < w + 2) tick();
        send_byte(H0);
        send_byte(H1);
        send_byte(8'h00);
        uart_rx_ren   = 1'b1;
        uart_rx_rdata = 8'hDE;
        rst_sys       = 1'b1;
        tick();
        uart_rx_ren = 1'b0;
        check_all_zero("abort", 1'b0);
        rst_sys = 1'b0;
        #1;
        check("abort_rdy_after_release", req_rdy, 1'b1);
        last_rsp.status = 8'h00;
        last_rsp.data   = 32'h0;
        last_rsp.err    = 2'b00;
        repeat (5) tick();

        // Randomized transactions
        for (int t = 0; t < 24; t++) begin
            logic [7:0]  st;
            logic [31:0] dd;
            int          sum;
            rdy_rand = 1'b1;
            issue_req(8'($urandom), 16'($urandom), $urandom);
            wait_tx_done(w);
            rdy_rand    = 1'b0;
            uart_tx_rdy = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                push_timeout(w);
            end else begin
                s    = {};
                prev = 8'h00;
                n    = $urandom_range(0, 4);
                for (int k = 0; k < n; k++) begin
                    case ($urandom_range(0, 2))
                        0:       b = H0;
                        1:       b = H1;
                        default: b = 8'($urandom);
                    endcase
                    if (prev == H0 && b == H1) b = 8'h56;
                    s.push_back(b);
                    prev = b;
                end
                st  = 8'($urandom);
                dd  = $urandom;
                sum = int'(st) + int'(dd[31:24]) + int'(dd[23:16]) + int'(dd[15:8]) + int'(dd[7:0]);
                if ($urandom_range(0, 3) == 0) sum = sum + $urandom_range(1, 255);
                s.push_back(H0);
                s.push_back(H1);
                s.push_back(st);
                s.push_back(dd[31:24]);
                s.push_back(dd[23:16]);
                s.push_back(dd[15:8]);
                s.push_back(dd[7:0]);
                s.push_back(8'(sum % 256));
                send_rsp(s, w, $urandom_range(0, 3), 3);
            end
            wait_rsp_done();
        end

        repeat (5) tick();
        finish_test();
    end

endmodule
